// File: rtl/rect_fill_if.sv
// rect_fill_if: command and pixel-write bundle for rect_fill_engine.
// master: command source / write-port arbiter side (drives command and grant).
// slave : the fill engine (drives status and the pixel write port).
interface rect_fill_if #(
    parameter int h_size      = 640,
    parameter int v_line      = 480,
    parameter int color_depth = 8
);
    localparam int xw = $clog2(h_size);
    localparam int yw = $clog2(v_line);

    // command side
    logic                   start;
    logic [xw-1:0]          x0;
    logic [yw-1:0]          y0;
    logic [xw-1:0]          x1;
    logic [yw-1:0]          y1;
    logic [color_depth-1:0] color;
    logic                   outline;

    // status
    logic                   ready;
    logic                   busy;
    logic                   done;

    // pixel memory write port
    logic                   wr_grant;
    logic                   write_en;
    logic [xw-1:0]          h_pixel_write;
    logic [yw-1:0]          v_pixel_write;
    logic [color_depth-1:0] color_write;

    modport master (
        output start, x0, y0, x1, y1, color, outline, wr_grant,
        input  ready, busy, done, write_en, h_pixel_write, v_pixel_write, color_write
    );

    modport slave (
        input  start, x0, y0, x1, y1, color, outline, wr_grant,
        output ready, busy, done, write_en, h_pixel_write, v_pixel_write, color_write
    );
endinterface

// File: rtl/rect_fill_engine.sv
// rect_fill_engine: fills an axis-aligned rectangle with one colour, one pixel
// per granted cycle, row-major, on the frame-buffer write port.
// Optional outline-only mode is built when RECT_FILL_OUTLINE_EN is defined;
// otherwise the outline input is ignored.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a command; start latches clipped bounds + colour
// FILL  | cursor walks the rectangle, advancing only on wr_grant
// DONE  | one-cycle done pulse, then back to IDLE
module rect_fill_engine #(
    parameter int h_size      = 640,
    parameter int v_line      = 480,
    parameter int color_depth = 8
) (
    input logic       clk,
    input logic       reset,
    rect_fill_if.slave bus
);
    localparam int xw = $clog2(h_size);
    localparam int yw = $clog2(v_line);

    localparam logic [xw-1:0] x_last = xw'(h_size - 1);
    localparam logic [yw-1:0] y_last = yw'(v_line - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [xw-1:0]          cur_x, xmin, xmax;
    logic [yw-1:0]          cur_y, ymin, ymax;
    logic [color_depth-1:0] col;

    logic [xw-1:0] lo_x, hi_x, clip_x;
    logic [yw-1:0] lo_y, hi_y, clip_y;
    logic          off_screen;

    logic load;
    logic advance;
    logic x_at_end, y_at_end, last_pix;
    logic jump;

    // Normalise the incoming corners and clip the far edge to the screen.
    always_comb begin
        lo_x       = (bus.x0 < bus.x1) ? bus.x0 : bus.x1;
        hi_x       = (bus.x0 < bus.x1) ? bus.x1 : bus.x0;
        lo_y       = (bus.y0 < bus.y1) ? bus.y0 : bus.y1;
        hi_y       = (bus.y0 < bus.y1) ? bus.y1 : bus.y0;
        clip_x     = (hi_x > x_last) ? x_last : hi_x;
        clip_y     = (hi_y > y_last) ? y_last : hi_y;
        // Near corner beyond the last pixel means nothing is visible.
        off_screen = (lo_x > x_last) || (lo_y > y_last);
    end

    // Cursor position relative to the latched bounds.
    always_comb begin
        x_at_end = (cur_x == xmax);
        y_at_end = (cur_y == ymax);
        last_pix = x_at_end && y_at_end;
    end

`ifdef RECT_FILL_OUTLINE_EN
    logic outl;

    // On interior rows of an outline, skip straight from the left edge to the right edge.
    always_comb begin
        jump = outl && (cur_y != ymin) && (cur_y != ymax) && (cur_x == xmin);
    end
`else
    // Outline mode not built: the cursor always steps by one pixel.
    always_comb begin
        jump = 1'b0;
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt    = state;
        bus.ready    = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.write_en = 1'b0;
        load         = 1'b0;
        advance      = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) begin
                    if (off_screen) begin
                        state_nxt = DONE;
                    end else begin
                        load      = 1'b1;
                        state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                bus.busy     = 1'b1;
                // Grant gates the registered cursor directly so a lent port costs no cycle.
                bus.write_en = bus.wr_grant;
                if (bus.wr_grant) begin
                    advance = 1'b1;
                    if (last_pix) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Bounds, colour and cursor: latched on an accepted command, stepped on each granted write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_x <= '0;
            cur_y <= '0;
            xmin  <= '0;
            xmax  <= '0;
            ymin  <= '0;
            ymax  <= '0;
            col   <= '0;
        end else if (load) begin
            xmin  <= lo_x;
            xmax  <= clip_x;
            ymin  <= lo_y;
            ymax  <= clip_y;
            col   <= bus.color;
            cur_x <= lo_x;
            cur_y <= lo_y;
        end else if (advance && !last_pix) begin
            if (!x_at_end) begin
                cur_x <= jump ? xmax : cur_x + xw'(1);
            end else begin
                cur_x <= xmin;
                cur_y <= cur_y + yw'(1);
            end
        end
    end

`ifdef RECT_FILL_OUTLINE_EN
    // Outline mode is captured with the command so later port changes do not matter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outl <= 1'b0;
        end else if (load) begin
            outl <= bus.outline;
        end
    end
`endif

    // Write port presents the live cursor and the latched colour.
    always_comb begin
        bus.h_pixel_write = cur_x;
        bus.v_pixel_write = cur_y;
        bus.color_write   = col;
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// tb_rect_fill_engine: directed vector table plus hand-written stall and
// reset-mid-fill sequences for rect_fill_engine.
module tb_rect_fill_engine;

    localparam int H = 640;
    localparam int V = 480;
    localparam int C = 8;

`ifdef RECT_FILL_OUTLINE_EN
    localparam int OUTL_N = 12;
    localparam bit OUTL_ON = 1'b1;
`else
    localparam int OUTL_N = 16;
    localparam bit OUTL_ON = 1'b0;
`endif

    typedef struct {
        logic [9:0] x0;
        logic [8:0] y0;
        logic [9:0] x1;
        logic [8:0] y1;
        logic [7:0] color;
        logic       outline;
        int         bx0;
        int         bx1;
        int         by0;
        int         by1;
        int         exp_n;
        int         exp_done;
    } vec_t;

    logic clk;
    logic reset;

    rect_fill_if #(.h_size(H), .v_line(V), .color_depth(C)) ifc ();

    rect_fill_engine #(.h_size(H), .v_line(V), .color_depth(C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    int qx[$];
    int qy[$];

    vec_t vecs[12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference pixel list for a rectangle given its hand-clipped bounds.
    task automatic build_exp(input vec_t v);
        qx.delete();
        qy.delete();
        if (v.exp_n > 0) begin
            for (int y = v.by0; y <= v.by1; y++) begin
                for (int x = v.bx0; x <= v.bx1; x++) begin
                    if (!(OUTL_ON && v.outline && y != v.by0 && y != v.by1 &&
                          x != v.bx0 && x != v.bx1)) begin
                        qx.push_back(x);
                        qy.push_back(y);
                    end
                end
            end
        end
    endtask

    // Issue one command; grant is low on cycles st_lo..st_hi after start.
    // Entered and left just after a rising edge.
    task automatic run_cmd(input vec_t v, input int st_lo, input int st_hi);
        int  c;
        int  nw;
        bit  got_done;
        logic g;
        build_exp(v);
        ifc.x0       = v.x0;
        ifc.y0       = v.y0;
        ifc.x1       = v.x1;
        ifc.y1       = v.y1;
        ifc.color    = v.color;
        ifc.outline  = v.outline;
        ifc.wr_grant = 1'b1;
        ifc.start    = 1'b1;
        @(negedge clk);
        chk("ready_before_start", ifc.ready, 1);
        @(posedge clk);
        #1;
        // Disturb command inputs to confirm they were latched.
        ifc.start   = 1'b0;
        ifc.x0      = ~v.x0;
        ifc.x1      = 10'd0;
        ifc.y0      = ~v.y0;
        ifc.y1      = 9'd0;
        ifc.color   = ~v.color;
        ifc.outline = ~v.outline;
        c        = 1;
        nw       = 0;
        got_done = 1'b0;
        while (c <= 2000 && !got_done) begin
            g = !(c >= st_lo && c <= st_hi);
            ifc.wr_grant = g;
            @(negedge clk);
            if (c == 1) chk("ready_after_start", ifc.ready, 0);
            if (ifc.done) begin
                got_done = 1'b1;
                chk("done_cycle", c, v.exp_done);
                chk("write_count", nw, v.exp_n);
                chk("pixels_left", qx.size(), 0);
                chk("we_in_done", ifc.write_en, 0);
                chk("busy_in_done", ifc.busy, 0);
            end else begin
                chk("busy_fill", ifc.busy, 1);
                chk("we_gating", ifc.write_en, g);
                if (qx.size() > 0) begin
                    chk("cursor_x", ifc.h_pixel_write, qx[0]);
                    chk("cursor_y", ifc.v_pixel_write, qy[0]);
                end
                if (ifc.write_en) begin
                    chk("write_color", ifc.color_write, v.color);
                    if (qx.size() == 0) begin
                        chk("extra_write", 1, 0);
                    end else begin
                        void'(qx.pop_front());
                        void'(qy.pop_front());
                    end
                    nw++;
                end
            end
            @(posedge clk);
            #1;
            c++;
        end
        if (!got_done) chk("done_timeout", 0, 1);
        ifc.wr_grant = 1'b1;
        @(negedge clk);
        chk("done_one_cycle", ifc.done, 0);
        chk("ready_after_done", ifc.ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        // x0, y0, x1, y1, color, outline, bx0, bx1, by0, by1, n, done
        vecs[0]  = '{10'd2,   9'd3,   10'd4,   9'd4,   8'hA5, 1'b0, 2,   4,   3,   4,   6,  7};
        vecs[1]  = '{10'd645, 9'd479, 10'd638, 9'd479, 8'h3C, 1'b0, 638, 639, 479, 479, 2,  3};
        vecs[2]  = '{10'd700, 9'd10,  10'd700, 9'd10,  8'h11, 1'b0, 0,   0,   0,   0,   0,  1};
        vecs[3]  = '{10'd5,   9'd5,   10'd5,   9'd5,   8'h5A, 1'b0, 5,   5,   5,   5,   1,  2};
        vecs[4]  = '{10'd9,   9'd7,   10'd6,   9'd5,   8'hC3, 1'b0, 6,   9,   5,   7,   12, 13};
        vecs[5]  = '{10'd0,   9'd0,   10'd3,   9'd3,   8'hFF, 1'b1, 0,   3,   0,   3,   OUTL_N, OUTL_N + 1};
        vecs[6]  = '{10'd639, 9'd479, 10'd639, 9'd479, 8'h81, 1'b0, 639, 639, 479, 479, 1,  2};
        vecs[7]  = '{10'd0,   9'd470, 10'd0,   9'd500, 8'h24, 1'b0, 0,   0,   470, 479, 10, 11};
        vecs[8]  = '{10'd0,   9'd490, 10'd5,   9'd490, 8'h66, 1'b0, 0,   0,   0,   0,   0,  1};
        vecs[9]  = '{10'd3,   9'd3,   10'd3,   9'd0,   8'h99, 1'b1, 3,   3,   0,   3,   4,  5};
        vecs[10] = '{10'd1,   9'd2,   10'd0,   9'd0,   8'h0F, 1'b1, 0,   1,   0,   2,   6,  7};
        vecs[11] = '{10'd4,   9'd4,   10'd2,   9'd2,   8'hE7, 1'b0, 2,   4,   2,   4,   9,  10};

        ifc.start    = 1'b0;
        ifc.x0       = '0;
        ifc.y0       = '0;
        ifc.x1       = '0;
        ifc.y1       = '0;
        ifc.color    = '0;
        ifc.outline  = 1'b0;
        ifc.wr_grant = 1'b1;
        reset        = 1'b1;
        #1;
        chk("rst_ready", ifc.ready, 1);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_done", ifc.done, 0);
        chk("rst_we", ifc.write_en, 0);
        chk("rst_hx", ifc.h_pixel_write, 0);
        chk("rst_vy", ifc.v_pixel_write, 0);
        chk("rst_col", ifc.color_write, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            run_cmd(vecs[i], 0, -1);
        end

        // Grant stall: 2x2 fill, port lent on cycles 2..4.
        v = '{10'd0, 9'd0, 10'd1, 9'd1, 8'h3E, 1'b0, 0, 1, 0, 1, 4, 8};
        run_cmd(v, 2, 4);

        // Reset asserted during the third write of a 4x4 fill.
        ifc.x0       = 10'd3;
        ifc.y0       = 9'd2;
        ifc.x1       = 10'd6;
        ifc.y1       = 9'd5;
        ifc.color    = 8'h77;
        ifc.outline  = 1'b0;
        ifc.wr_grant = 1'b1;
        ifc.start    = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_we_before_rst", ifc.write_en, 1);
        chk("mid_x_before_rst", ifc.h_pixel_write, 5);
        reset = 1'b1;
        #1;
        chk("mid_rst_we", ifc.write_en, 0);
        chk("mid_rst_busy", ifc.busy, 0);
        chk("mid_rst_done", ifc.done, 0);
        chk("mid_rst_ready", ifc.ready, 1);
        chk("mid_rst_hx", ifc.h_pixel_write, 0);
        chk("mid_rst_col", ifc.color_write, 0);
        @(posedge clk);
        #1;
        chk("rst_held_busy", ifc.busy, 0);
        reset = 1'b0;
        v = '{10'd11, 9'd20, 10'd10, 9'd20, 8'h42, 1'b0, 10, 11, 20, 20, 2, 3};
        run_cmd(v, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
- Sequencer that drives the write port of the frame-buffer pixel memory. It fills an axis-aligned rectangle with one colour, one pixel per cycle, in row-major order.
- Sits between the command source (CPU bus bridge / GPU command decoder) and the pixel memory write side.
- Yields the write port to a higher-priority master via a grant input.

Parameters:
- h_size, 640, horizontal resolution in pixels.
- v_line, 480, vertical resolution in lines.
- color_depth, 8, bits per pixel.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  command strobe; sampled only when ready=1.
- x0  input  $clog2(h_size)  first corner, horizontal.
- y0  input  $clog2(v_line)  first corner, vertical.
- x1  input  $clog2(h_size)  opposite corner, horizontal.
- y1  input  $clog2(v_line)  opposite corner, vertical.
- color  input  color_depth  fill colour.
- outline  input  1  outline-only mode (see Optional Feature).
- wr_grant  input  1  1 = engine may write this cycle; 0 = port lent to another master.
- ready  output  1  idle, command accepted on start.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.
- write_en  output  1  pixel memory write enable.
- h_pixel_write  output  $clog2(h_size)  write X.
- v_pixel_write  output  $clog2(v_line)  write Y.
- color_write  output  color_depth  write colour.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-fill):
  - state=IDLE, ready=1, busy=0, done=0, write_en=0.
  - h_pixel_write=0, v_pixel_write=0, color_write=0.
  - No pending command survives reset.
- States: IDLE, FILL, DONE.
- IDLE:
  - start=1 latches colour and normalised bounds:
    - xmin=min(x0,x1), xmax=min(max(x0,x1), h_size-1).
    - ymin=min(y0,y1), ymax=min(max(y0,y1), v_line-1).
  - If xmin>=h_size or ymin>=v_line (rectangle fully off-screen), go to DONE with no writes; otherwise go to FILL with cursor=(xmin,ymin).
  - ready=0 from the cycle after start.
- FILL:
  - busy=1.
  - write_en = wr_grant (combinational gating of the registered cursor). Outputs present the current cursor and latched colour.
  - If wr_grant=1: the cursor advances at the clock edge:
    - x<xmax: x+1.
    - x==xmax, y<ymax: x=xmin, y+1.
    - x==xmax, y==ymax: go to DONE.
  - If wr_grant=0: cursor holds, no pixel is skipped or duplicated.
  - start is ignored while in FILL.
- DONE:
  - done=1 and busy=0 for exactly one cycle, write_en=0, then IDLE.
  - ready=1 again the cycle after done.
- Latency with wr_grant held at 1:
  - First write_en is asserted in the cycle after start.
  - W=xmax-xmin+1, H=ymax-ymin+1: exactly W*H consecutive write cycles, then the done pulse.
  - Start to done = W*H+1 cycles.
- Degenerate cases:
  - Single pixel (x0=x1, y0=y1): 1 write.
  - Swapped corners produce the same result as ordered corners.
- Write coordinates never equal all-ones when h_size/v_line are not powers of two; clipping guarantees X<h_size and Y<v_line.
- Widths: all comparisons are unsigned at port width; no arithmetic wraps because the cursor is bounded by the clipped max.

Optional Feature:
- Macro: RECT_FILL_OUTLINE_EN.
- Defined, with outline latched =1 at start: only border pixels are written (x==xmin, x==xmax, y==ymin or y==ymax).
  - On interior rows the cursor jumps from xmin directly to xmax; interior pixels cost no cycles.
  - Write count for W>=2, H>=2: 2W+2(H-2).
  - Write count for W==1 or H==1: W*H.
- Not defined: the outline port is ignored (treated as 0) and the jump logic is not synthesised.

Test Plan:
- Basic fill: start with x0=2, y0=3, x1=4, y1=4, color=0xA5, wr_grant=1 -> 6 writes at (2,3)(3,3)(4,3)(2,4)(3,4)(4,4), all color_write=0xA5; done at cycle 7 after start.
- Swapped and clipped: x0=645, x1=638, y0=479, y1=479 (640x480) -> writes only at (638,479), (639,479); then done.
- Off-screen and single pixel:
  - x0=x1=700 -> no write_en; done the cycle after start.
  - x0=x1=5, y0=y1=5 -> exactly 1 write.
- Grant stall: 2x2 fill with wr_grant=0 on cycles 2-4 -> write_en low during the stall, coordinates held at (1,0)-equivalent; each of the 4 pixels written once; start-to-done = 4+3+1 cycles.
- Reset mid-fill: assert reset during the 3rd write of a 4x4 fill -> write_en, busy, done go 0 immediately, ready=1; a new start after release fills correctly from its own xmin/ymin.
- Outline (macro defined): 4x4 at (0,0), outline=1 -> 12 writes, none at (1,1),(2,1),(1,2),(2,2); done at cycle 13.
